call_stack_tracker: RTL and testbench
=====================================

# call_stack_tracker

Hardware call-hierarchy tracker that sits directly downstream of the function-call event source. It consumes call and return events and keeps a bounded LIFO of active frames, each holding a function ID and a return address. It exposes the current frame, the nesting depth, and the frame retired by each return. It flags overflow and underflow with sticky error bits, so the call nesting produced by upstream code (f1 → f2 → f3 style chains) can be checked cycle by cycle.

## Interface
Parameters:
- DEPTH, 8, maximum number of live frames (≥2)
- ID_W, 4, function ID width
- ADDR_W, 16, return address width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- call_valid  in  1  call event this cycle
- call_id  in  ID_W  callee function ID
- call_addr  in  ADDR_W  return address to save
- ret_valid  in  1  return event this cycle
- clr_err  in  1  clears sticky error flags
- top_valid  out  1  stack non-empty (alias of !empty)
- top_id  out  ID_W  ID of innermost frame; 0 when empty
- top_addr  out  ADDR_W  return address of innermost frame; 0 when empty
- depth  out  $clog2(DEPTH+1)  live frame count
- empty  out  1  depth == 0
- full  out  1  depth == DEPTH
- pop_valid  out  1  one-cycle pulse: a frame was retired
- pop_id  out  ID_W  ID of retired frame
- pop_addr  out  ADDR_W  return address of retired frame
- overflow  out  1  sticky: call dropped while full
- underflow  out  1  sticky: return while empty

## Operation
- Storage: DEPTH-entry register array plus a depth pointer. Entry index depth-1 is the top.
- Call only, not full: write {call_id, call_addr} at index depth; depth+1.
- Call only, full: frame dropped; stack unchanged; overflow←1.
- Return only, not empty: depth−1; pop_valid←1; pop_id/pop_addr←old top.
- Return only, empty: no change; underflow←1; pop_valid stays 0.
- Call and return, not empty (tail call): old top retired, so pop_valid←1 with the old top; new frame overwrites the top index; depth unchanged. This holds when full; overflow is not set.
- Call and return, empty: underflow←1; the call is pushed; depth becomes 1; pop_valid 0.
- clr_err: clears overflow and underflow. A new error event in the same cycle wins, so the flag stays 1.
- top_id, top_addr, empty, full and top_valid are combinational from registered state. They read 0 when empty.
- depth never wraps; it saturates logically at 0 and DEPTH through the rules above.

## Timing
- Event at edge N is reflected in depth, top_* and flags after edge N (visible in cycle N+1).
- pop_valid, pop_id and pop_addr are registered. They are valid for exactly the cycle after the return edge and deasserted otherwise. pop_id and pop_addr hold their last value when pop_valid is 0.
- Back-to-back events every cycle are supported with no stall. There is no ready signal and the block always accepts.
- Reset (rst_n=0 at an edge):
  - depth=0, empty=1, full=0, top_valid=0, top_id=0, top_addr=0
  - pop_valid=0, pop_id=0, pop_addr=0, overflow=0, underflow=0
  - Array contents need not be cleared.
- Reset mid-sequence discards all frames. Events presented in the reset cycle are ignored.

## Configuration
- CALL_STACK_MAX_DEPTH_EN defined:
  - Adds output max_depth, width $clog2(DEPTH+1), a high-water mark of depth.
  - Updated the same edge depth grows. Reset to 0. Cleared to the current depth on clr_err.
- CALL_STACK_MAX_DEPTH_EN undefined: the port and its register are absent. All other behaviour is identical.

## Test plan
- Calls (id 1, 0x0100), (id 2, 0x0200), (id 3, 0x0300) on consecutive cycles → depth=3, top_id=3, top_addr=0x0300; max_depth=3 if enabled.
- Three returns after the above → pop pulses with ids 3, 2, 1 and addrs 0x0300, 0x0200, 0x0100 on consecutive cycles; then empty=1, top_id=0.
- DEPTH=8: 9 calls → full=1, depth=8, overflow=1, top_id is the 8th ID. Then clr_err → overflow=0.
- Return when empty → underflow=1, pop_valid=0, depth=0. Simultaneous call (id 5) and return when empty → depth=1, top_id=5, underflow=1.
- Depth 2 with top id 2; simultaneous call (id 7, 0x0700) and return → pop_id=2, depth=2, top_id=7, top_addr=0x0700. Repeat when full → overflow stays 0.
- Depth 4; assert rst_n=0 with call_valid=1 → next cycle depth=0, all outputs 0, and no push occurred.

Source files
------------

// File: rtl/call_stack_tracker.sv
// ============================================================================
//  Module   : call_stack_tracker
//  Purpose  : Bounded LIFO of call frames {id, return address} driven by
//             call/return events; reports top frame, depth, retired frames
//             and sticky overflow/underflow flags.
//  Options  : CALL_STACK_MAX_DEPTH_EN adds the max_depth high-water output.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module call_stack_tracker #(
   parameter int DEPTH  = 8,
   parameter int ID_W   = 4,
   parameter int ADDR_W = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         call_valid,
   input  logic [ID_W-1:0]              call_id,
   input  logic [ADDR_W-1:0]            call_addr,
   input  logic                         ret_valid,
   input  logic                         clr_err,
   output logic                         top_valid,
   output logic [ID_W-1:0]              top_id,
   output logic [ADDR_W-1:0]            top_addr,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         empty,
   output logic                         full,
   output logic                         pop_valid,
   output logic [ID_W-1:0]              pop_id,
   output logic [ADDR_W-1:0]            pop_addr,
   output logic                         overflow,
`ifdef CALL_STACK_MAX_DEPTH_EN
   output logic [$clog2(DEPTH+1)-1:0]   max_depth,
`endif
   output logic                         underflow
);

   localparam int c_DW  = $clog2(DEPTH + 1);
   localparam int c_AW  = $clog2(DEPTH);
   localparam int c_FW  = ID_W + ADDR_W;
   localparam logic [c_DW-1:0] c_FULL_CNT = c_DW'(DEPTH);

   logic [c_FW-1:0]   stack_q [DEPTH];
   logic [c_DW-1:0]   depth_q,     depth_d;
   logic              pop_valid_q, pop_valid_d;
   logic [ID_W-1:0]   pop_id_q,    pop_id_d;
   logic [ADDR_W-1:0] pop_addr_q,  pop_addr_d;
   logic              ovf_q,       ovf_d;
   logic              udf_q,       udf_d;

   logic              w_empty;
   logic              w_full;
   logic [c_AW-1:0]   w_top_idx;
   logic [c_AW-1:0]   w_wr_idx;
   logic [c_FW-1:0]   w_top_rec;
   logic              w_wr_en;
   logic              w_inc;
   logic              w_dec;
   logic              w_pop;

   always_comb begin
      w_empty   = (depth_q == '0);
      w_full    = (depth_q == c_FULL_CNT);
      w_top_idx = c_AW'(depth_q - c_DW'(1));
      w_top_rec = stack_q[w_top_idx];

      // A tail call replaces the live top; every other push lands above it.
      w_wr_idx  = (ret_valid && !w_empty) ? w_top_idx : c_AW'(depth_q);
      w_wr_en   = call_valid && (ret_valid || !w_full);
      w_inc     = call_valid && (ret_valid ? w_empty : !w_full);
      w_dec     = ret_valid && !call_valid && !w_empty;
      w_pop     = ret_valid && !w_empty;

      depth_d = depth_q;
      if (w_inc) begin
         depth_d = depth_q + c_DW'(1);
      end else if (w_dec) begin
         depth_d = depth_q - c_DW'(1);
      end

      pop_valid_d = w_pop;
      pop_id_d    = pop_id_q;
      pop_addr_d  = pop_addr_q;
      if (w_pop) begin
         pop_id_d   = w_top_rec[c_FW-1:ADDR_W];
         pop_addr_d = w_top_rec[ADDR_W-1:0];
      end

      // A fresh error in the same cycle as clr_err keeps the flag set.
      ovf_d = (call_valid && !ret_valid && w_full) || (ovf_q && !clr_err);
      udf_d = (ret_valid && w_empty) || (udf_q && !clr_err);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         depth_q     <= '0;
         pop_valid_q <= 1'b0;
         pop_id_q    <= '0;
         pop_addr_q  <= '0;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
      end else begin
         depth_q     <= depth_d;
         pop_valid_q <= pop_valid_d;
         pop_id_q    <= pop_id_d;
         pop_addr_q  <= pop_addr_d;
         ovf_q       <= ovf_d;
         udf_q       <= udf_d;
      end
   end

   // Frame storage carries no reset; stale entries are never visible.
   always_ff @(posedge clk) begin
      if (rst_n && w_wr_en) begin
         stack_q[w_wr_idx] <= {call_id, call_addr};
      end
   end

`ifdef CALL_STACK_MAX_DEPTH_EN
   logic [c_DW-1:0] max_q, max_d;
   logic [c_DW-1:0] w_max_base;

   always_comb begin
      w_max_base = clr_err ? depth_q : max_q;
      max_d      = (depth_d > w_max_base) ? depth_d : w_max_base;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         max_q <= '0;
      end else begin
         max_q <= max_d;
      end
   end

   assign max_depth = max_q;
`endif

   assign depth     = depth_q;
   assign empty     = w_empty;
   assign full      = w_full;
   assign top_valid = !w_empty;
   assign top_id    = w_empty ? '0 : w_top_rec[c_FW-1:ADDR_W];
   assign top_addr  = w_empty ? '0 : w_top_rec[ADDR_W-1:0];
   assign pop_valid = pop_valid_q;
   assign pop_id    = pop_id_q;
   assign pop_addr  = pop_addr_q;
   assign overflow  = ovf_q;
   assign underflow = udf_q;

endmodule

`default_nettype wire

// File: tb/tb_call_stack_tracker.sv
// ============================================================================
//  Module   : tb_call_stack_tracker
//  Purpose  : Directed self-checking bench for call_stack_tracker (DEPTH=8).
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_call_stack_tracker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        call_valid;
   logic [3:0]  call_id;
   logic [15:0] call_addr;
   logic        ret_valid;
   logic        clr_err;
   logic        top_valid;
   logic [3:0]  top_id;
   logic [15:0] top_addr;
   logic [3:0]  depth;
   logic        empty;
   logic        full;
   logic        pop_valid;
   logic [3:0]  pop_id;
   logic [15:0] pop_addr;
   logic        overflow;
   logic        underflow;
`ifdef CALL_STACK_MAX_DEPTH_EN
   logic [3:0]  max_depth;
`endif

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   call_stack_tracker #(.DEPTH(8), .ID_W(4), .ADDR_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .call_valid (call_valid),
      .call_id    (call_id),
      .call_addr  (call_addr),
      .ret_valid  (ret_valid),
      .clr_err    (clr_err),
      .top_valid  (top_valid),
      .top_id     (top_id),
      .top_addr   (top_addr),
      .depth      (depth),
      .empty      (empty),
      .full       (full),
      .pop_valid  (pop_valid),
      .pop_id     (pop_id),
      .pop_addr   (pop_addr),
      .overflow   (overflow),
`ifdef CALL_STACK_MAX_DEPTH_EN
      .max_depth  (max_depth),
`endif
      .underflow  (underflow)
   );

   // One clock with the given events; outputs are sampled 1ns after the edge.
   task automatic cyc(input logic c, input logic [3:0] id, input logic [15:0] addr,
                      input logic r, input logic clr);
      call_valid = c;
      call_id    = id;
      call_addr  = addr;
      ret_valid  = r;
      clr_err    = clr;
      @(posedge clk);
      #1;
      call_valid = 1'b0;
      ret_valid  = 1'b0;
      clr_err    = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      cyc(1'b1, 4'd9, 16'h0900, 1'b0, 1'b0);
      cyc(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
      rst_n = 1'b1;
      vectors++; if (depth !== 4'd0)      begin miscompares++; $display("FAIL reset_depth got %0d want 0", depth); end
      vectors++; if (empty !== 1'b1)      begin miscompares++; $display("FAIL reset_empty got %b want 1", empty); end
      vectors++; if (full !== 1'b0)       begin miscompares++; $display("FAIL reset_full got %b want 0", full); end
      vectors++; if (top_valid !== 1'b0)  begin miscompares++; $display("FAIL reset_top_valid got %b want 0", top_valid); end
      vectors++; if (top_id !== 4'd0)     begin miscompares++; $display("FAIL reset_top_id got %0d want 0", top_id); end
      vectors++; if (top_addr !== 16'h0)  begin miscompares++; $display("FAIL reset_top_addr got %h want 0", top_addr); end
      vectors++; if (pop_valid !== 1'b0)  begin miscompares++; $display("FAIL reset_pop_valid got %b want 0", pop_valid); end
      vectors++; if (pop_id !== 4'd0)     begin miscompares++; $display("FAIL reset_pop_id got %0d want 0", pop_id); end
      vectors++; if (pop_addr !== 16'h0)  begin miscompares++; $display("FAIL reset_pop_addr got %h want 0", pop_addr); end
      vectors++; if (overflow !== 1'b0)   begin miscompares++; $display("FAIL reset_overflow got %b want 0", overflow); end
      vectors++; if (underflow !== 1'b0)  begin miscompares++; $display("FAIL reset_underflow got %b want 0", underflow); end
   endtask

   task automatic test_calls;
      cyc(1'b1, 4'd1, 16'h0100, 1'b0, 1'b0);
      vectors++; if (depth !== 4'd1 || top_id !== 4'd1) begin miscompares++; $display("FAIL call1 depth=%0d top_id=%0d want 1/1", depth, top_id); end
      cyc(1'b1, 4'd2, 16'h0200, 1'b0, 1'b0);
      cyc(1'b1, 4'd3, 16'h0300, 1'b0, 1'b0);
      vectors++; if (depth !== 4'd3)        begin miscompares++; $display("FAIL calls_depth got %0d want 3", depth); end
      vectors++; if (top_id !== 4'd3)       begin miscompares++; $display("FAIL calls_top_id got %0d want 3", top_id); end
      vectors++; if (top_addr !== 16'h0300) begin miscompares++; $display("FAIL calls_top_addr got %h want 0300", top_addr); end
      vectors++; if (top_valid !== 1'b1 || empty !== 1'b0) begin miscompares++; $display("FAIL calls_valid top_valid=%b empty=%b want 1/0", top_valid, empty); end
      vectors++; if (pop_valid !== 1'b0)    begin miscompares++; $display("FAIL calls_pop_valid got %b want 0", pop_valid); end
`ifdef CALL_STACK_MAX_DEPTH_EN
      vectors++; if (max_depth !== 4'd3)    begin miscompares++; $display("FAIL calls_max_depth got %0d want 3", max_depth); end
`endif
   endtask

   task automatic test_returns;
      logic [3:0]  exp_id   [3] = '{4'd3, 4'd2, 4'd1};
      logic [15:0] exp_addr [3] = '{16'h0300, 16'h0200, 16'h0100};
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
         vectors++;
         if (pop_valid !== 1'b1 || pop_id !== exp_id[i] || pop_addr !== exp_addr[i] || depth !== 4'(2 - i)) begin
            miscompares++;
            $display("FAIL ret%0d pv=%b id=%0d addr=%h depth=%0d want 1/%0d/%h/%0d",
                     i, pop_valid, pop_id, pop_addr, depth, exp_id[i], exp_addr[i], 2 - i);
         end
      end
      vectors++; if (empty !== 1'b1 || top_id !== 4'd0 || top_addr !== 16'h0) begin miscompares++; $display("FAIL ret_empty empty=%b top_id=%0d top_addr=%h want 1/0/0", empty, top_id, top_addr); end
      cyc(1'b0, 4'd0, 16'h0, 1'b0, 1'b0);
      vectors++; if (pop_valid !== 1'b0 || pop_id !== 4'd1 || pop_addr !== 16'h0100) begin miscompares++; $display("FAIL ret_hold pv=%b id=%0d addr=%h want 0/1/0100", pop_valid, pop_id, pop_addr); end
      vectors++; if (underflow !== 1'b0)  begin miscompares++; $display("FAIL ret_no_underflow got %b want 0", underflow); end
   endtask

   task automatic test_overflow;
      for (int i = 1; i <= 8; i++) cyc(1'b1, 4'(i), 16'(i * 256), 1'b0, 1'b0);
      vectors++; if (full !== 1'b1 || depth !== 4'd8 || overflow !== 1'b0) begin miscompares++; $display("FAIL fill full=%b depth=%0d ovf=%b want 1/8/0", full, depth, overflow); end
      cyc(1'b1, 4'd9, 16'h0900, 1'b0, 1'b0);
      vectors++; if (overflow !== 1'b1)     begin miscompares++; $display("FAIL ovf_flag got %b want 1", overflow); end
      vectors++; if (depth !== 4'd8 || full !== 1'b1) begin miscompares++; $display("FAIL ovf_depth depth=%0d full=%b want 8/1", depth, full); end
      vectors++; if (top_id !== 4'd8 || top_addr !== 16'h0800) begin miscompares++; $display("FAIL ovf_top id=%0d addr=%h want 8/0800", top_id, top_addr); end
`ifdef CALL_STACK_MAX_DEPTH_EN
      vectors++; if (max_depth !== 4'd8)    begin miscompares++; $display("FAIL ovf_max_depth got %0d want 8", max_depth); end
`endif
      cyc(1'b1, 4'd10, 16'h0A00, 1'b0, 1'b1);
      vectors++; if (overflow !== 1'b1)     begin miscompares++; $display("FAIL ovf_clr_race got %b want 1", overflow); end
      cyc(1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
      vectors++; if (overflow !== 1'b0 || depth !== 4'd8) begin miscompares++; $display("FAIL ovf_clr ovf=%b depth=%0d want 0/8", overflow, depth); end
      // Tail call while full: no overflow, depth unchanged.
      cyc(1'b1, 4'd7, 16'h0700, 1'b1, 1'b0);
      vectors++; if (pop_valid !== 1'b1 || pop_id !== 4'd8 || pop_addr !== 16'h0800) begin miscompares++; $display("FAIL full_tail_pop pv=%b id=%0d addr=%h want 1/8/0800", pop_valid, pop_id, pop_addr); end
      vectors++; if (depth !== 4'd8 || top_id !== 4'd7 || top_addr !== 16'h0700 || overflow !== 1'b0) begin miscompares++; $display("FAIL full_tail depth=%0d id=%0d addr=%h ovf=%b want 8/7/0700/0", depth, top_id, top_addr, overflow); end
      for (int i = 0; i < 8; i++) cyc(1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
      vectors++; if (empty !== 1'b1 || pop_id !== 4'd1 || underflow !== 1'b0) begin miscompares++; $display("FAIL drain empty=%b last_id=%0d udf=%b want 1/1/0", empty, pop_id, underflow); end
   endtask

   task automatic test_underflow;
      cyc(1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
      vectors++; if (underflow !== 1'b1 || pop_valid !== 1'b0 || depth !== 4'd0) begin miscompares++; $display("FAIL udf udf=%b pv=%b depth=%0d want 1/0/0", underflow, pop_valid, depth); end
      cyc(1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
      vectors++; if (underflow !== 1'b0)    begin miscompares++; $display("FAIL udf_clr got %b want 0", underflow); end
      cyc(1'b1, 4'd5, 16'h0500, 1'b1, 1'b0);
      vectors++; if (depth !== 4'd1 || top_id !== 4'd5 || top_addr !== 16'h0500) begin miscompares++; $display("FAIL empty_tail depth=%0d id=%0d addr=%h want 1/5/0500", depth, top_id, top_addr); end
      vectors++; if (underflow !== 1'b1 || pop_valid !== 1'b0) begin miscompares++; $display("FAIL empty_tail_flags udf=%b pv=%b want 1/0", underflow, pop_valid); end
      cyc(1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
      vectors++; if (pop_valid !== 1'b1 || pop_id !== 4'd5 || empty !== 1'b1) begin miscompares++; $display("FAIL udf_pop pv=%b id=%0d empty=%b want 1/5/1", pop_valid, pop_id, empty); end
      cyc(1'b0, 4'd0, 16'h0, 1'b1, 1'b1);
      vectors++; if (underflow !== 1'b1)    begin miscompares++; $display("FAIL udf_clr_race got %b want 1", underflow); end
      cyc(1'b0, 4'd0, 16'h0, 1'b0, 1'b1);
      vectors++; if (underflow !== 1'b0)    begin miscompares++; $display("FAIL udf_clr2 got %b want 0", underflow); end
   endtask

   task automatic test_tail_call;
      cyc(1'b1, 4'd1, 16'h0100, 1'b0, 1'b0);
      cyc(1'b1, 4'd2, 16'h0200, 1'b0, 1'b0);
      vectors++; if (depth !== 4'd2 || top_id !== 4'd2) begin miscompares++; $display("FAIL tail_setup depth=%0d id=%0d want 2/2", depth, top_id); end
      cyc(1'b1, 4'd7, 16'h0700, 1'b1, 1'b0);
      vectors++; if (pop_valid !== 1'b1 || pop_id !== 4'd2 || pop_addr !== 16'h0200) begin miscompares++; $display("FAIL tail_pop pv=%b id=%0d addr=%h want 1/2/0200", pop_valid, pop_id, pop_addr); end
      vectors++; if (depth !== 4'd2 || top_id !== 4'd7 || top_addr !== 16'h0700) begin miscompares++; $display("FAIL tail_top depth=%0d id=%0d addr=%h want 2/7/0700", depth, top_id, top_addr); end
      cyc(1'b0, 4'd0, 16'h0, 1'b1, 1'b0);
      vectors++; if (pop_id !== 4'd7 || depth !== 4'd1 || top_id !== 4'd1 || top_addr !== 16'h0100) begin miscompares++; $display("FAIL tail_unwind pop=%0d depth=%0d id=%0d addr=%h want 7/1/1/0100", pop_id, depth, top_id, top_addr); end
   endtask

   task automatic test_reset_mid;
      cyc(1'b1, 4'd2, 16'h0200, 1'b0, 1'b0);
      cyc(1'b1, 4'd3, 16'h0300, 1'b0, 1'b0);
      cyc(1'b1, 4'd4, 16'h0400, 1'b1, 1'b0);
      cyc(1'b1, 4'd6, 16'h0600, 1'b0, 1'b0);
      vectors++; if (depth !== 4'd4 || top_id !== 4'd6) begin miscompares++; $display("FAIL mid_setup depth=%0d id=%0d want 4/6", depth, top_id); end
      rst_n = 1'b0;
      cyc(1'b1, 4'd12, 16'h0C00, 1'b0, 1'b0);
      rst_n = 1'b1;
      vectors++; if (depth !== 4'd0 || empty !== 1'b1 || top_valid !== 1'b0 || top_id !== 4'd0 || top_addr !== 16'h0) begin miscompares++; $display("FAIL mid_reset depth=%0d empty=%b tv=%b id=%0d addr=%h want 0/1/0/0/0", depth, empty, top_valid, top_id, top_addr); end
      vectors++; if (pop_valid !== 1'b0 || pop_id !== 4'd0 || pop_addr !== 16'h0 || overflow !== 1'b0 || underflow !== 1'b0) begin miscompares++; $display("FAIL mid_reset_regs pv=%b id=%0d addr=%h ovf=%b udf=%b want all 0", pop_valid, pop_id, pop_addr, overflow, underflow); end
`ifdef CALL_STACK_MAX_DEPTH_EN
      vectors++; if (max_depth !== 4'd0)    begin miscompares++; $display("FAIL mid_reset_max got %0d want 0", max_depth); end
`endif
      cyc(1'b1, 4'd9, 16'h0900, 1'b0, 1'b0);
      vectors++; if (depth !== 4'd1 || top_id !== 4'd9 || top_addr !== 16'h0900) begin miscompares++; $display("FAIL post_reset_call depth=%0d id=%0d addr=%h want 1/9/0900", depth, top_id, top_addr); end
   endtask

   initial begin
      rst_n      = 1'b0;
      call_valid = 1'b0;
      call_id    = '0;
      call_addr  = '0;
      ret_valid  = 1'b0;
      clr_err    = 1'b0;
      @(negedge clk);
      test_reset();
      test_calls();
      test_returns();
      test_overflow();
      test_underflow();
      test_tail_call();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
